// File: rtl/servo_pkg.sv
// Shared constants and types for the multi-channel servo PWM generator.
// Holds the default timing/width parameters and the legacy 2-bit direction codes.
package servo_pkg;

    localparam int unsigned DEF_NUM_CH   = 2;
    localparam int unsigned DEF_CNT_W    = 6;
    localparam int unsigned DEF_PERIOD   = 40;
    localparam int unsigned DEF_MIN_W    = 2;
    localparam int unsigned DEF_MAX_W    = 4;
    localparam int unsigned DEF_CENTER_W = 3;
    localparam int unsigned DEF_STEP     = 1;

    // Legacy steering direction codes from the original fixed 3-way decoder.
    typedef enum logic [1:0] {
        DIR_MID   = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10
    } dir_e;

    // Pulse width, in counts, that each legacy direction code used to produce.
    function automatic int unsigned dir_width(input dir_e dir);
        case (dir)
            DIR_LEFT:  return DEF_MAX_W;
            DIR_RIGHT: return DEF_MIN_W;
            default:   return DEF_CENTER_W;
        endcase
    endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Channel-target write bus for servo_pwm_multi.
// The master drives a one-cycle wr_en strobe with the channel index and requested width.
interface servo_pwm_multi_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 6
) ();

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_width;

    modport master (output wr_en, output wr_ch, output wr_width);
    modport slave  (input  wr_en, input  wr_ch, input  wr_width);

endinterface

// File: rtl/servo_ch.sv
// One servo PWM channel: target register with clamping, period-boundary update of the
// active width, and registered pwm/settled outputs.
// Optional macro SERVO_SLEW_LIMIT_EN limits the active-width change per period to STEP.
module servo_ch
    import servo_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned MIN_W    = DEF_MIN_W,
    parameter int unsigned MAX_W    = DEF_MAX_W,
    parameter int unsigned CENTER_W = DEF_CENTER_W,
    parameter int unsigned STEP     = DEF_STEP
) (
    input  logic             clk_dec,
    input  logic             rst_n,
    input  logic             en,
    input  logic             boundary,
    input  logic [CNT_W-1:0] cnt_next,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_width,
    output logic             pwm,
    output logic             settled
);

    localparam int unsigned XW = CNT_W + 1;
    localparam logic [CNT_W:0] MIN_X = XW'(MIN_W);
    localparam logic [CNT_W:0] MAX_X = XW'(MAX_W);

`ifdef SERVO_SLEW_LIMIT_EN
    localparam int unsigned MAX_MOVE = STEP;
`else
    // A permitted move larger than any possible width difference makes active_w snap to target.
    localparam int unsigned MAX_MOVE = STEP + (1 << CNT_W);
`endif
    localparam logic [CNT_W:0] MOVE_X = XW'(MAX_MOVE);

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] active_w;
    logic [CNT_W-1:0] target_next;
    logic [CNT_W-1:0] active_w_next;
    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] moved;
    logic [CNT_W:0]   wr_x;
    logic [CNT_W:0]   tgt_x;
    logic [CNT_W:0]   act_x;
    logic [CNT_W:0]   diff;
    logic [CNT_W:0]   stepped;

    // Clamp incoming writes and compute the boundary move of active_w toward the held target.
    always_comb begin
        wr_x    = {1'b0, wr_width};
        clamped = wr_width;
        diff    = '0;
        stepped = '0;

        if (wr_x < MIN_X) begin
            clamped = CNT_W'(MIN_W);
        end else if (wr_x > MAX_X) begin
            clamped = CNT_W'(MAX_W);
        end

        target_next = wr ? clamped : target;

        tgt_x = {1'b0, target};
        act_x = {1'b0, active_w};
        if (tgt_x >= act_x) begin
            diff    = tgt_x - act_x;
            stepped = act_x + MOVE_X;
        end else begin
            diff    = act_x - tgt_x;
            stepped = act_x - MOVE_X;
        end

        moved         = (32'(diff) <= MAX_MOVE) ? target : CNT_W'(stepped);
        active_w_next = boundary ? moved : active_w;
    end

    // Target/active width registers and the registered pwm and settled outputs.
    always_ff @(posedge clk_dec or negedge rst_n) begin
        if (!rst_n) begin
            target   <= CNT_W'(CENTER_W);
            active_w <= CNT_W'(CENTER_W);
            pwm      <= 1'b0;
            settled  <= 1'b1;
        end else begin
            target   <= target_next;
            active_w <= active_w_next;
            pwm      <= en && (cnt_next <= active_w_next);
            settled  <= (active_w_next == target_next);
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo/steering PWM generator running on clk_dec.
// Owns the shared 1..PERIOD counter, period_start and write decode; one servo_ch per channel.
// Optional macro SERVO_SLEW_LIMIT_EN enables per-period slew limiting in every channel.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned PERIOD   = DEF_PERIOD,
    parameter int unsigned MIN_W    = DEF_MIN_W,
    parameter int unsigned MAX_W    = DEF_MAX_W,
    parameter int unsigned CENTER_W = DEF_CENTER_W,
    parameter int unsigned STEP     = DEF_STEP
) (
    input  logic              clk_dec,
    input  logic              rst_n,
    input  logic              en,
    servo_pwm_multi_if.slave  wr_bus,
    output logic [NUM_CH-1:0] pwm,
    output logic              period_start,
    output logic [NUM_CH-1:0] settled
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              boundary;
    logic [NUM_CH-1:0] wr_sel;

    // Next counter value; a disabled generator parks at PERIOD so re-enabling starts at 1.
    always_comb begin
        cnt_next = cnt;
        if (!en) begin
            cnt_next = CNT_W'(PERIOD);
        end else if (cnt == CNT_W'(PERIOD)) begin
            cnt_next = CNT_W'(1);
        end else begin
            cnt_next = cnt + 1'b1;
        end
        boundary = en && (cnt_next == CNT_W'(1));
    end

    // One-hot channel select; indices at or beyond NUM_CH match nothing and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = wr_bus.wr_en && (wr_bus.wr_ch == CH_W'(i));
        end
    end

    // Shared period counter and period_start pulse.
    always_ff @(posedge clk_dec or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= CNT_W'(PERIOD);
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            period_start <= boundary;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_ch #(
            .CNT_W    (CNT_W),
            .MIN_W    (MIN_W),
            .MAX_W    (MAX_W),
            .CENTER_W (CENTER_W),
            .STEP     (STEP)
        ) u_ch (
            .clk_dec  (clk_dec),
            .rst_n    (rst_n),
            .en       (en),
            .boundary (boundary),
            .cnt_next (cnt_next),
            .wr       (wr_sel[g]),
            .wr_width (wr_bus.wr_width),
            .pwm      (pwm[g]),
            .settled  (settled[g])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: directed scenarios plus randomized traffic
// checked against a period-level behavioural model of the generator.
module tb_servo_pwm_multi;
    import servo_pkg::*;

    localparam int unsigned NCH  = 2;
    localparam int unsigned CW   = 6;
    localparam int unsigned PER  = 40;
    localparam int unsigned MINW = 2;
    localparam int unsigned MAXW = 4;
    localparam int unsigned CTRW = 3;
    localparam int unsigned STP  = 1;

    logic clk_dec = 1'b0;
    always #5 clk_dec = ~clk_dec;

    logic             rst_n;
    logic             en;
    logic [NCH-1:0]   pwm;
    logic             period_start;
    logic [NCH-1:0]   settled;

    logic             en3;
    logic [2:0]       pwm3;
    logic             ps3;
    logic [2:0]       set3;

    servo_pwm_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) wr_bus ();
    servo_pwm_multi_if #(.NUM_CH(3),   .CNT_W(CW)) wr_bus3 ();

    servo_pwm_multi #(
        .NUM_CH(NCH), .CNT_W(CW), .PERIOD(PER), .MIN_W(MINW),
        .MAX_W(MAXW), .CENTER_W(CTRW), .STEP(STP)
    ) dut (
        .clk_dec(clk_dec), .rst_n(rst_n), .en(en), .wr_bus(wr_bus.slave),
        .pwm(pwm), .period_start(period_start), .settled(settled)
    );

    servo_pwm_multi #(
        .NUM_CH(3), .CNT_W(CW), .PERIOD(PER), .MIN_W(MINW),
        .MAX_W(MAXW), .CENTER_W(CTRW), .STEP(STP)
    ) dut3 (
        .clk_dec(clk_dec), .rst_n(rst_n), .en(en3), .wr_bus(wr_bus3.slave),
        .pwm(pwm3), .period_start(ps3), .settled(set3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: position within the period, requested and applied widths.
    int       m_cnt;
    int       m_tgt [NCH];
    int       m_act [NCH];
    logic [NCH-1:0] m_pwm;
    logic     m_ps;
    logic [NCH-1:0] m_set;

    function automatic int clampw(input int w);
        if (w < int'(MINW)) return MINW;
        if (w > int'(MAXW)) return MAXW;
        return w;
    endfunction

    task automatic model_reset();
        m_cnt = PER;
        for (int i = 0; i < NCH; i++) begin
            m_tgt[i] = CTRW;
            m_act[i] = CTRW;
        end
        m_pwm = '0;
        m_ps  = 1'b0;
        m_set = '1;
    endtask

    task automatic model_step(input bit e, input bit we, input int ch, input int w);
        bit bnd;
        if (e) m_cnt = (m_cnt == int'(PER)) ? 1 : m_cnt + 1;
        else   m_cnt = PER;
        bnd = e && (m_cnt == 1);
        if (bnd) begin
            for (int i = 0; i < NCH; i++) begin
`ifdef SERVO_SLEW_LIMIT_EN
                int d;
                d = m_tgt[i] - m_act[i];
                if (d > int'(STP))       m_act[i] = m_act[i] + STP;
                else if (d < -int'(STP)) m_act[i] = m_act[i] - STP;
                else                     m_act[i] = m_tgt[i];
`else
                m_act[i] = m_tgt[i];
`endif
            end
        end
        if (we && ch >= 0 && ch < NCH) m_tgt[ch] = clampw(w);
        for (int i = 0; i < NCH; i++) begin
            m_pwm[i] = e && (m_cnt >= 1) && (m_cnt <= m_act[i]);
            m_set[i] = (m_act[i] == m_tgt[i]);
        end
        m_ps = bnd;
    endtask

    // Drive one clock of inputs, advance the model alongside, and land 1 ns past the edge.
    task automatic step(input bit e, input bit we, input int ch, input int w);
        en              = e;
        wr_bus.wr_en    = we;
        wr_bus.wr_ch    = 1'(ch);
        wr_bus.wr_width = CW'(w);
        @(posedge clk_dec);
        model_step(e, we, ch, w);
        #1;
        wr_bus.wr_en = 1'b0;
    endtask

    // Run until the model sits on the last count of a period, so the next step starts one.
    task automatic seek_period_end();
        int guard = 0;
        while (m_cnt != int'(PER) && guard < 50) begin
            step(1'b1, 1'b0, 0, 0);
            guard++;
        end
        n_cmp++;
        if (m_cnt != int'(PER)) begin
            n_bad++;
            $display("FAIL seek_period_end: cnt=%0d required=%0d", m_cnt, PER);
        end
    endtask

    task automatic run_count(input int n, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 0, 0);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        en3 = 1'b0;
        wr_bus.wr_en = 1'b0;  wr_bus.wr_ch = '0;  wr_bus.wr_width = '0;
        wr_bus3.wr_en = 1'b0; wr_bus3.wr_ch = '0; wr_bus3.wr_width = '0;
        model_reset();
        #12;
        n_cmp++;
        if (pwm !== 2'b00) begin n_bad++; $display("FAIL reset_pwm: got=%b required=00", pwm); end
        n_cmp++;
        if (period_start !== 1'b0) begin n_bad++; $display("FAIL reset_ps: got=%b required=0", period_start); end
        n_cmp++;
        if (settled !== 2'b11) begin n_bad++; $display("FAIL reset_settled: got=%b required=11", settled); end
        rst_n = 1'b1;
    endtask

    task automatic test_default();
        int h0 = 0;
        int nps = 0;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'b0, 0, 0);
            if (i == 0) begin
                n_cmp++;
                if (period_start !== 1'b1) begin n_bad++; $display("FAIL first_start: ps=%b required=1", period_start); end
            end
            if (i < 40) h0 += int'(pwm[0]);
            nps += int'(period_start);
            if (period_start === 1'b1) begin
                n_cmp++;
                if (pwm !== 2'b11) begin n_bad++; $display("FAIL start_rise: pwm=%b required=11", pwm); end
            end
            n_cmp++;
            if (pwm !== m_pwm || period_start !== m_ps || settled !== m_set) begin
                n_bad++;
                $display("FAIL default_cycle%0d: pwm=%b ps=%b set=%b required pwm=%b ps=%b set=%b",
                         i, pwm, period_start, settled, m_pwm, m_ps, m_set);
            end
        end
        n_cmp++;
        if (h0 != 3) begin n_bad++; $display("FAIL default_high: got=%0d required=3", h0); end
        n_cmp++;
        if (nps != 2) begin n_bad++; $display("FAIL default_starts: got=%0d required=2", nps); end
    endtask

    task automatic test_write_mid();
        int h0, h1, c0, c1;
        seek_period_end();
        step(1'b1, 1'b0, 0, 0);
        c0 = int'(pwm[0]);
        c1 = int'(pwm[1]);
        step(1'b1, 1'b0, 0, 0);
        c0 += int'(pwm[0]);
        c1 += int'(pwm[1]);
        step(1'b1, 1'b1, 1, dir_width(DIR_LEFT));
        c0 += int'(pwm[0]);
        c1 += int'(pwm[1]);
        n_cmp++;
        if (settled !== 2'b01) begin n_bad++; $display("FAIL write_unsettled: got=%b required=01", settled); end
        run_count(37, h0, h1);
        c0 += h0;
        c1 += h1;
        n_cmp++;
        if (c1 != 3) begin n_bad++; $display("FAIL write_cur_ch1: got=%0d required=3", c1); end
        run_count(40, h0, h1);
        n_cmp++;
        if (h1 != 4) begin n_bad++; $display("FAIL write_next_ch1: got=%0d required=4", h1); end
        n_cmp++;
        if (h0 != 3 || c0 != 3) begin n_bad++; $display("FAIL write_ch0: got=%0d,%0d required=3,3", c0, h0); end
        n_cmp++;
        if (settled !== 2'b11) begin n_bad++; $display("FAIL write_settled: got=%b required=11", settled); end
    endtask

    task automatic test_clamp();
        int h0, h1;
        seek_period_end();
        step(1'b1, 1'b1, 0, 0);
        step(1'b1, 1'b1, 1, dir_width(DIR_MID));
        run_count(38, h0, h1);
        run_count(40, h0, h1);
        n_cmp++;
        if (h0 != 2 || h1 != 3) begin n_bad++; $display("FAIL clamp_low: got=%0d,%0d required=2,3", h0, h1); end
        step(1'b1, 1'b1, 1, dir_width(DIR_RIGHT));
        step(1'b1, 1'b1, 1, 9);
        step(1'b1, 1'b1, 0, dir_width(DIR_MID));
        run_count(37, h0, h1);
        run_count(40, h0, h1);
        n_cmp++;
        if (h0 != 3 || h1 != 4) begin n_bad++; $display("FAIL clamp_high_lastwins: got=%0d,%0d required=3,4", h0, h1); end
    endtask

    task automatic test_illegal_ch();
        int hc [3];
        bit all_set = 1'b1;
        hc = '{0, 0, 0};
        en3 = 1'b1;
        wr_bus3.wr_en = 1'b1;
        wr_bus3.wr_ch = 2'd3;
        wr_bus3.wr_width = CW'(4);
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'b0, 0, 0);
            wr_bus3.wr_en = 1'b0;
            for (int c = 0; c < 3; c++) hc[c] += int'(pwm3[c]);
            if (set3 !== 3'b111) all_set = 1'b0;
        end
        en3 = 1'b0;
        n_cmp++;
        if (hc[0] != 6 || hc[1] != 6 || hc[2] != 6) begin
            n_bad++;
            $display("FAIL illegal_ch_width: got=%0d,%0d,%0d required=6,6,6", hc[0], hc[1], hc[2]);
        end
        n_cmp++;
        if (!all_set) begin n_bad++; $display("FAIL illegal_ch_settled: got=0 required=1"); end
    endtask

    task automatic test_enable();
        seek_period_end();
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        n_cmp++;
        if (pwm !== 2'b11) begin n_bad++; $display("FAIL en_pre_high: got=%b required=11", pwm); end
        step(1'b0, 1'b0, 0, 0);
        n_cmp++;
        if (pwm !== 2'b00 || period_start !== 1'b0) begin
            n_bad++;
            $display("FAIL en_drop: pwm=%b ps=%b required pwm=00 ps=0", pwm, period_start);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        n_cmp++;
        if (pwm !== 2'b11 || period_start !== 1'b1) begin
            n_bad++;
            $display("FAIL en_restart: pwm=%b ps=%b required pwm=11 ps=1", pwm, period_start);
        end
    endtask

    task automatic test_random();
        int lbad = 0;
        for (int i = 0; i < 600; i++) begin
            bit e, we;
            int ch, w;
            e  = ($urandom_range(0, 9) != 0);
            we = ($urandom_range(0, 3) == 0);
            ch = $urandom_range(0, NCH - 1);
            w  = $urandom_range(0, 63);
            step(e, we, ch, w);
            n_cmp++;
            if (pwm !== m_pwm || period_start !== m_ps || settled !== m_set) begin
                n_bad++;
                lbad++;
                if (lbad <= 10)
                    $display("FAIL random_cycle%0d: pwm=%b ps=%b set=%b required pwm=%b ps=%b set=%b",
                             i, pwm, period_start, settled, m_pwm, m_ps, m_set);
            end
        end
    endtask

    task automatic test_async_reset();
        int h0, h1;
        seek_period_end();
        step(1'b1, 1'b1, 0, dir_width(DIR_LEFT));
        step(1'b1, 1'b1, 1, dir_width(DIR_RIGHT));
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pwm !== 2'b00) begin n_bad++; $display("FAIL async_pwm: got=%b required=00", pwm); end
        n_cmp++;
        if (settled !== 2'b11 || period_start !== 1'b0) begin
            n_bad++;
            $display("FAIL async_state: set=%b ps=%b required set=11 ps=0", settled, period_start);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 0, 0);
        n_cmp++;
        if (period_start !== 1'b1) begin n_bad++; $display("FAIL async_restart: ps=%b required=1", period_start); end
        h0 = int'(pwm[0]);
        h1 = int'(pwm[1]);
        begin
            int a0, a1;
            run_count(39, a0, a1);
            h0 += a0;
            h1 += a1;
        end
        n_cmp++;
        if (h0 != 3 || h1 != 3) begin n_bad++; $display("FAIL async_targets: got=%0d,%0d required=3,3", h0, h1); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default();
        test_write_mid();
        test_clamp();
        test_illegal_ch();
        test_enable();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
